// File: rtl/awmc_actuator_driver.sv
// awmc_actuator_driver: turns controller stage/done into registered valve, pump, motor, door-lock and buzzer drive.
module awmc_actuator_driver #(
   parameter int AGIT_ON    = 8,
   parameter int AGIT_GAP   = 4,
   parameter int RAMP_CYC   = 6,
   parameter int UNLOCK_DLY = 5,
   parameter int BUZZ_CYC   = 3
) (
   input  logic       clk_i,
   input  logic       reset_i,
   input  logic [2:0] stage_i,
   input  logic       done_i,
   input  logic       pause_i,
   input  logic       lid_i,
   output logic       valve_in_o,
   output logic       pump_out_o,
   output logic       motor_en_o,
   output logic       motor_dir_o,
   output logic [1:0] motor_speed_o,
   output logic       door_lock_o,
   output logic       buzzer_o,
   output logic       fault_o
);
   typedef enum logic [2:0] {A_IDLE, A_FILL, A_FWD, A_GAP1, A_REV, A_GAP2, A_SPIN, A_DRAIN} state_t;
   localparam int M0 = AGIT_ON > AGIT_GAP ? AGIT_ON : AGIT_GAP;
   localparam int M1 = RAMP_CYC > UNLOCK_DLY ? RAMP_CYC : UNLOCK_DLY;
   localparam int M2 = M0 > M1 ? M0 : M1;
   localparam int MAXP = M2 > BUZZ_CYC ? M2 : BUZZ_CYC;
   localparam int CW = $clog2(MAXP) + 1;
   localparam logic [CW-1:0] ON_L = CW'(AGIT_ON - 1);
   localparam logic [CW-1:0] GAP_L = CW'(AGIT_GAP - 1);
   localparam logic [CW-1:0] RAMP_L = CW'(RAMP_CYC - 1);
   localparam logic [CW-1:0] UNL = CW'(UNLOCK_DLY);
   localparam logic [CW-1:0] BUZ = CW'(BUZZ_CYC);
   state_t state_q, state_d;
   logic [2:0] stg_q, stg_d;
   logic [CW-1:0] cnt_q, cnt_d, tmr_q, tmr_d, bcnt_q, bcnt_d, lim;
   logic [1:0] spd_q, spd_d, speed_q, speed_d;
   logic done_q, hold, last, timed;
   logic valve_q, valve_d, pump_q, pump_d, motor_q, motor_d, dir_q, dir_d;
   logic lock_q, lock_d, buzz_q, buzz_d, fault_q, fault_d;
   always_comb begin
      stg_d = (stage_i > 3'd5) ? 3'd0 : stage_i;
      hold = pause_i | ~lid_i;
      state_d = state_q;
      cnt_d = cnt_q;
      spd_d = spd_q;
      lim = (state_q == A_FWD || state_q == A_REV) ? ON_L :
            (state_q == A_GAP1 || state_q == A_GAP2) ? GAP_L : RAMP_L;
      last = cnt_q == lim;
      timed = state_q != A_IDLE && state_q != A_FILL && state_q != A_DRAIN;
      // A stage change wins over hold so the new state starts clean while outputs stay gated.
      if (stg_d != stg_q) begin
         cnt_d = '0;
         spd_d = 2'd1;
         state_d = stg_d == 3'd1 ? A_FILL :
                   (stg_d == 3'd2 || stg_d == 3'd3) ? A_FWD :
                   stg_d == 3'd4 ? A_SPIN :
                   stg_d == 3'd5 ? A_DRAIN : A_IDLE;
      end else if (!hold && timed) begin
         cnt_d = last ? '0 : cnt_q + 1'b1;
         if (last && state_q == A_SPIN) spd_d = (spd_q == 2'd3) ? 2'd3 : spd_q + 2'd1;
         else if (last) state_d = (state_q == A_GAP2) ? A_FWD : state_t'(state_q + 3'd1);
      end
      motor_d = ~hold & (state_d == A_FWD || state_d == A_REV || state_d == A_SPIN);
      dir_d = motor_d & (state_d == A_REV);
      speed_d = !motor_d ? 2'd0 : (state_d == A_SPIN) ? spd_d : 2'd1;
      valve_d = ~hold & (state_d == A_FILL || (stg_d == 3'd3 && state_d >= A_FWD && state_d <= A_GAP2));
      pump_d = ~hold & (state_d == A_SPIN || state_d == A_DRAIN);
      tmr_d = motor_d ? UNL : (tmr_q != '0) ? tmr_q - 1'b1 : '0;
      lock_d = (state_d != A_IDLE) | (tmr_d != '0);
      fault_d = fault_q | (~lid_i & motor_q);
      bcnt_d = (done_i & ~done_q) ? BUZ : (bcnt_q != '0) ? bcnt_q - 1'b1 : '0;
      buzz_d = bcnt_d != '0;
   end
   always_ff @(posedge clk_i) begin
      if (!reset_i) begin
         state_q <= A_IDLE;
         stg_q <= '0;
         cnt_q <= '0;
         spd_q <= '0;
         tmr_q <= '0;
         bcnt_q <= '0;
         done_q <= 1'b0;
         valve_q <= 1'b0;
         pump_q <= 1'b0;
         motor_q <= 1'b0;
         dir_q <= 1'b0;
         speed_q <= '0;
         lock_q <= 1'b0;
         buzz_q <= 1'b0;
         fault_q <= 1'b0;
      end else begin
         state_q <= state_d;
         stg_q <= stg_d;
         cnt_q <= cnt_d;
         spd_q <= spd_d;
         tmr_q <= tmr_d;
         bcnt_q <= bcnt_d;
         done_q <= done_i;
         valve_q <= valve_d;
         pump_q <= pump_d;
         motor_q <= motor_d;
         dir_q <= dir_d;
         speed_q <= speed_d;
         lock_q <= lock_d;
         buzz_q <= buzz_d;
         fault_q <= fault_d;
      end
   end
   assign valve_in_o = valve_q;
   assign pump_out_o = pump_q;
   assign motor_en_o = motor_q;
   assign motor_dir_o = dir_q;
   assign motor_speed_o = speed_q;
   assign door_lock_o = lock_q;
   assign buzzer_o = buzz_q;
   assign fault_o = fault_q;
endmodule

// File: tb/tb_awmc_actuator_driver.sv
// tb_awmc_actuator_driver: random and directed stimulus checked against a time-based reference model.
module tb_awmc_actuator_driver;
   localparam int ON = 8, GAP = 4, RAMP = 6, UNL = 5, BUZ = 3;
   logic clk = 1'b0, reset = 1'b0, done = 1'b0, pause = 1'b0, lid = 1'b1;
   logic [2:0] stage = 3'd2;
   logic valve_in, pump_out, motor_en, motor_dir, door_lock, buzzer, fault;
   logic [1:0] motor_speed;
   int n_chk = 0, n_pass = 0;
   int n = 0, ticks = 0, pstage = 0, last_m = -1000, last_d = -1000;
   bit pdone = 0, f = 0;
   int e_valve = 0, e_pump = 0, e_men = 0, e_dir = 0, e_spd = 0, e_lock = 0, e_buzz = 0, e_fault = 0;

   awmc_actuator_driver dut (
      .clk_i(clk), .reset_i(reset), .stage_i(stage), .done_i(done), .pause_i(pause), .lid_i(lid),
      .valve_in_o(valve_in), .pump_out_o(pump_out), .motor_en_o(motor_en), .motor_dir_o(motor_dir),
      .motor_speed_o(motor_speed), .door_lock_o(door_lock), .buzzer_o(buzzer), .fault_o(fault)
   );

   always #5 clk = ~clk;

   task automatic chk(input string tag, input int got, input int exp);
      n_chk++;
      if (got == exp) n_pass++;
      else $display("FAIL %s at cycle %0d: got %0d, expected %0d", tag, n, got, exp);
   endtask

   // Behaviour expressed as elapsed unheld cycles since stage entry and time since last events.
   task automatic model();
      int ds, ph, spd;
      bit hold, on, rev;
      n++;
      ds = (stage > 3'd5) ? 0 : int'(stage);
      if (!reset) begin
         pstage = 0; ticks = 0; pdone = 0; f = 0; last_m = -1000; last_d = -1000;
         e_valve = 0; e_pump = 0; e_men = 0; e_dir = 0; e_spd = 0; e_lock = 0; e_buzz = 0; e_fault = 0;
         return;
      end
      hold = pause || !lid;
      f = f || (!lid && e_men != 0);
      if (ds != pstage) begin
         pstage = ds;
         ticks = 0;
      end else if (!hold) ticks++;
      if (done && !pdone) last_d = n;
      pdone = done;
      on = 0; rev = 0; spd = 0;
      if (pstage == 2 || pstage == 3) begin
         ph = ticks % (2 * (ON + GAP));
         on = (ph < ON) || (ph >= ON + GAP && ph < 2 * ON + GAP);
         rev = ph >= ON + GAP;
         spd = 1;
      end else if (pstage == 4) begin
         on = 1;
         spd = (1 + ticks / RAMP > 3) ? 3 : 1 + ticks / RAMP;
      end
      e_men = int'(on && !hold);
      e_dir = int'(e_men != 0 && rev);
      e_spd = (e_men != 0) ? spd : 0;
      e_valve = int'(!hold && (pstage == 1 || pstage == 3));
      e_pump = int'(!hold && (pstage == 4 || pstage == 5));
      if (e_men != 0) last_m = n;
      e_lock = int'(pstage != 0 || n - last_m < UNL);
      e_buzz = int'(n - last_d < BUZ);
      e_fault = int'(f);
   endtask

   task automatic step(input int cycles);
      for (int i = 0; i < cycles; i++) begin
         @(posedge clk);
         model();
         #1;
         chk("valve_in", int'(valve_in), e_valve);
         chk("pump_out", int'(pump_out), e_pump);
         chk("motor_en", int'(motor_en), e_men);
         chk("motor_dir", int'(motor_dir), e_dir);
         chk("motor_speed", int'(motor_speed), e_spd);
         chk("door_lock", int'(door_lock), e_lock);
         chk("buzzer", int'(buzzer), e_buzz);
         chk("fault", int'(fault), e_fault);
      end
   endtask

   initial begin
      step(2);
      reset = 1'b1;
      step(30);
      stage = 3'd3;
      step(30);
      stage = 3'd4;
      step(8);
      pause = 1'b1;
      step(10);
      pause = 1'b0;
      step(20);
      stage = 3'd2;
      step(5);
      lid = 1'b0;
      step(3);
      lid = 1'b1;
      step(2);
      stage = 3'd0;
      step(8);
      done = 1'b1;
      step(1);
      done = 1'b0;
      step(1);
      done = 1'b1;
      step(5);
      reset = 1'b0;
      step(2);
      reset = 1'b1;
      stage = 3'd1;
      step(4);
      stage = 3'd5;
      step(4);
      for (int i = 0; i < 3000; i++) begin
         reset = $urandom_range(99) != 0;
         if ($urandom_range(19) == 0) stage = 3'($urandom_range(7));
         if ($urandom_range(7) == 0) pause = ~pause;
         if ($urandom_range(11) == 0) lid = ~lid;
         if ($urandom_range(3) == 0) done = ~done;
         step(1);
      end
      $display("%0d/%0d checks passed", n_pass, n_chk);
      $finish;
   end
endmodule
